decoder_driver: RTL

- Sequential counterpart to the team's 4-to-2 encoder: accepts a binary code via a valid/ready handshake and drives the matching one-hot line for a programmable number of cycles.
- Inserts an all-zero break-before-make gap after each drive, pulses `done`, and keeps a running count of decoded codes.
- Sits between a command source and one-hot select lines, e.g. chip selects or mux enables.

---
 rtl/decoder_pkg.sv | 27 ++
 rtl/cycle_timer.sv | 33 +++
 rtl/decoder_driver.sv | 119 +++++++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// Shared definitions for the sequential one-hot decoder driver:
// FSM state encoding, default timing constants and the one-hot helper.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Default phase lengths in clock cycles.
  localparam int DEF_HOLD_CYCLES = 4;
  localparam int DEF_GAP_CYCLES  = 1;

  // Widest code the helper can decode; callers narrow the result with a size cast.
  localparam int MAX_CODE_W = 8;
  localparam int MAX_OUT_W  = 1 << MAX_CODE_W;

  // Binary code to one-hot vector.
  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_CODE_W-1:0] code);
    logic [MAX_OUT_W-1:0] vec;
    vec       = '0;
    vec[code] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter shared by the HOLD and GAP phases. It counts down
// to zero and parks there; a synchronous clear forces it back to zero.
module cycle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] value;

  // Clear beats load, load beats the free-running decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    if (!rst_n) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (value != '0) begin
      value <= value - 1'b1;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/decoder_driver.sv
// Accepts a binary code over valid/ready, drives the matching one-hot line for
// HOLD_CYCLES cycles, then holds all lines low for GAP_CYCLES cycles
// (break-before-make) before accepting again. Pulses done at the end of each
// completed drive and counts accepted codes. CODE_W must not exceed
// decoder_pkg::MAX_CODE_W.
module decoder_driver
  import decoder_pkg::*;
#(
  parameter  int CODE_W      = 2,
  parameter  int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter  int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter  int CNT_W       = 8,
  localparam int OUT_W       = 1 << CODE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic [OUT_W-1:0]  lines,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count
);

  // Timer load values; a zero-length gap never loads the timer.
  localparam int HOLD_LOAD = HOLD_CYCLES - 1;
  localparam int GAP_LOAD  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int LOAD_MAX  = (HOLD_LOAD > GAP_LOAD) ? HOLD_LOAD : GAP_LOAD;
  localparam int TIMER_W   = (LOAD_MAX < 1) ? 1 : $clog2(LOAD_MAX + 1);

  state_t             state;
  logic               accept;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_value;
  logic               timer_zero;

  assign in_ready = (state == IDLE) && !clear;
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;

  // Select when and with what the phase timer is reloaded.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    timer_load  = 1'b0;
    timer_value = TIMER_W'(HOLD_LOAD);
    unique case (state)
      IDLE: begin
        if (accept) begin
          timer_load  = 1'b1;
          timer_value = TIMER_W'(HOLD_LOAD);
        end
      end
      DRIVE: begin
        if (timer_zero && (GAP_CYCLES > 0)) begin
          timer_load  = 1'b1;
          timer_value = TIMER_W'(GAP_LOAD);
        end
      end
      default: ;
    endcase
  end

  cycle_timer #(
    .W (TIMER_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .load       (timer_load),
    .load_value (timer_value),
    .zero       (timer_zero)
  );

  // Phase FSM with the lines, done and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lines <= '0;
      done  <= 1'b0;
      count <= '0;
    end else if (clear) begin
      // Abort: no done pulse, count keeps its value.
      state <= IDLE;
      lines <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            lines <= OUT_W'(onehot(MAX_CODE_W'(in_code)));
            count <= count + CNT_W'(1);
            state <= DRIVE;
          end
        end
        DRIVE: begin
          if (timer_zero) begin
            lines <= '0;
            done  <= 1'b1;
            state <= (GAP_CYCLES > 0) ? GAP : IDLE;
          end
        end
        GAP: begin
          if (timer_zero) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          lines <= '0;
        end
      endcase
    end
  end

endmodule
